// File: rtl/ysyx_22040895_imem_resp_pkg.sv
// Shared fetch-bus types, constants and responder state encoding.
package ysyx_22040895_imem_resp_pkg;

  typedef logic [31:0] ysyx_22040895_InstBus;
  typedef logic [63:0] ysyx_22040895_InstAddrBus;

  localparam ysyx_22040895_InstBus     ysyx_22040895_NopInst  = 32'h0000_0013;
  localparam ysyx_22040895_InstAddrBus ysyx_22040895_ImemBase = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ysyx_22040895_IMEM_IDLE = 2'd0,
    ysyx_22040895_IMEM_WAIT = 2'd1,
    ysyx_22040895_IMEM_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/ysyx_22040895_imem_resp_if.sv
// Fetch request/response handshake plus the preload port, seen from core (master) and memory (slave).
interface ysyx_22040895_imem_resp_if
  import ysyx_22040895_imem_resp_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [ADDR_W-1:0]    req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  ysyx_22040895_InstBus rsp_inst_o;
  logic                 rsp_err_o;
  logic                 ld_we_i;
  logic [ADDR_W-1:0]    ld_addr_i;
  ysyx_22040895_InstBus ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );
endinterface

// File: rtl/ysyx_22040895_imem_resp_array.sv
// DEPTH x 32 instruction storage: one write port for preload, one registered read port.
module ysyx_22040895_imem_array
  import ysyx_22040895_imem_resp_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  ysyx_22040895_InstBus wdata,
  input  logic                 re,
  input  logic [IDX_W-1:0]     raddr,
  output ysyx_22040895_InstBus rdata
);
  ysyx_22040895_InstBus mem [DEPTH];

  // Non-blocking update means a same-edge write and read of one word returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/ysyx_22040895_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time and answers after LATENCY cycles.
module ysyx_22040895_imem_resp
  import ysyx_22040895_imem_resp_pkg::*;
#(
  parameter int                ADDR_W  = 64,
  parameter int                DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(ysyx_22040895_ImemBase),
  parameter int                LATENCY = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040895_imem_resp_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  // The addr<BASE term stops addresses below the window from wrapping onto valid words.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) | (a < BASE) | ((off >> 2) >= ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 2);
  endfunction

  imem_state_e          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rd_en;
  logic [IDX_W-1:0]     rd_idx;
  ysyx_22040895_InstBus rd_data;
  logic                 ld_en;
  logic [IDX_W-1:0]     ld_idx;

  assign ld_en  = bus.ld_we_i & ~addr_fault(bus.ld_addr_i);
  assign ld_idx = addr_index(bus.ld_addr_i);

  ysyx_22040895_imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_idx),
    .wdata (bus.ld_data_i),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ysyx_22040895_IMEM_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Faulting fetches still walk the full latency but never touch the array.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      ysyx_22040895_IMEM_IDLE: begin
        if (bus.req_valid_i) begin
          err_d = addr_fault(bus.req_addr_i);
          idx_d = addr_index(bus.req_addr_i);
          if (LATENCY == 1) begin
            state_d = ysyx_22040895_IMEM_RESP;
            rd_en   = ~err_d;
            rd_idx  = idx_d;
          end else begin
            state_d = ysyx_22040895_IMEM_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      ysyx_22040895_IMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ysyx_22040895_IMEM_RESP;
          rd_en   = ~err_q;
        end
      end
      ysyx_22040895_IMEM_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ysyx_22040895_IMEM_IDLE;
        end
      end
      default: state_d = ysyx_22040895_IMEM_IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == ysyx_22040895_IMEM_IDLE);
  assign bus.rsp_valid_o = (state_q == ysyx_22040895_IMEM_RESP);
  assign bus.rsp_err_o   = (state_q == ysyx_22040895_IMEM_RESP) & err_q;
  assign bus.rsp_inst_o  = (state_q != ysyx_22040895_IMEM_RESP) ? ysyx_22040895_NopInst :
                           (err_q ? 32'h0000_0000 : rd_data);
endmodule
